// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// branch_pkg : opcodes, condition codes, flag struct and FSM states for the
//              LEGv8 branch-resolution block.
// Rev 1.0
// ============================================================================
package branch_pkg;

  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_BCOND = 8'b0101_0100;
  localparam logic [7:0] OP_CBZ   = 8'b1011_0100;
  localparam logic [7:0] OP_CBNZ  = 8'b1011_0101;

  typedef enum logic [3:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_ctrl_cond_eval.sv
`default_nettype none
// ============================================================================
// cond_eval : combinational B.cond evaluation of a condition code against NZCV.
// Rev 1.0
// ============================================================================
module cond_eval
  import branch_pkg::*;
(
  input  cond_t cond_i,
  input  nzcv_t flags_i,
  output logic  taken_o
);

  logic w_ge;
  logic w_gt;
  logic w_hi;

  assign w_ge = (flags_i.n == flags_i.v);
  assign w_gt = !flags_i.z && w_ge;
  assign w_hi = flags_i.c && !flags_i.z;

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      EQ: taken_o = flags_i.z;
      NE: taken_o = !flags_i.z;
      HS: taken_o = flags_i.c;
      LO: taken_o = !flags_i.c;
      MI: taken_o = flags_i.n;
      PL: taken_o = !flags_i.n;
      VS: taken_o = flags_i.v;
      VC: taken_o = !flags_i.v;
      HI: taken_o = w_hi;
      LS: taken_o = !w_hi;
      GE: taken_o = w_ge;
      LT: taken_o = !w_ge;
      GT: taken_o = w_gt;
      LE: taken_o = !w_gt;
      default: taken_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// branch_ctrl : LEGv8 branch decode/resolve with NZCV register and flush FSM.
//               Optional BRANCH_STATS_EN adds branch / taken counters.
// Rev 1.0
// ============================================================================
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        set_flags,
  input  logic [3:0]  alu_flags,
  input  logic        cbz_zero,
  output logic        uncondBr,
  output logic        brTaken,
  output logic [18:0] condAddr19,
  output logic [25:0] brAddr26,
`ifdef BRANCH_STATS_EN
  output logic [31:0] br_count,
  output logic [31:0] taken_count,
`endif
  output logic        flush
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  nzcv_t       nzcv_q, nzcv_d;
  logic        uncond_q, uncond_d;
  logic        taken_q, taken_d;
  logic [18:0] c19_q, c19_d;
  logic [25:0] a26_q, a26_d;

  logic w_accept;
  logic w_is_b;
  logic w_is_bcond;
  logic w_is_cbz;
  logic w_is_cbnz;
  logic w_is_br;
  logic w_cond_taken;
  logic w_taken;

  // Condition is evaluated on the registered flags, so a same-cycle
  // flag update never influences the decision.
  cond_eval u_cond_eval (
    .cond_i  (cond_t'(instr[3:0])),
    .flags_i (nzcv_q),
    .taken_o (w_cond_taken)
  );

  assign w_accept   = instr_valid && (state_q == IDLE);
  assign w_is_b     = (instr[31:26] == OP_B) || (instr[31:26] == OP_BL);
  assign w_is_bcond = (instr[31:24] == OP_BCOND);
  assign w_is_cbz   = (instr[31:24] == OP_CBZ);
  assign w_is_cbnz  = (instr[31:24] == OP_CBNZ);
  assign w_is_br    = w_is_b || w_is_bcond || w_is_cbz || w_is_cbnz;
  assign w_taken    = w_is_b || (w_is_bcond && w_cond_taken) ||
                      (w_is_cbz && cbz_zero) || (w_is_cbnz && !cbz_zero);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nzcv_d   = nzcv_q;
    c19_d    = c19_q;
    a26_d    = a26_q;
    taken_d  = w_accept && w_is_br && w_taken;
    uncond_d = w_accept && w_is_b;

    if (w_accept && set_flags) begin
      nzcv_d = nzcv_t'(alu_flags);
    end
    if (w_accept && w_is_br) begin
      c19_d = instr[23:5];
      a26_d = instr[25:0];
    end

    case (state_q)
      IDLE: begin
        if (taken_d) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      nzcv_q   <= '0;
      uncond_q <= 1'b0;
      taken_q  <= 1'b0;
      c19_q    <= '0;
      a26_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nzcv_q   <= nzcv_d;
      uncond_q <= uncond_d;
      taken_q  <= taken_d;
      c19_q    <= c19_d;
      a26_q    <= a26_d;
    end
  end

  assign uncondBr   = uncond_q;
  assign brTaken    = taken_q;
  assign condAddr19 = c19_q;
  assign brAddr26   = a26_q;
  assign flush      = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] tk_cnt_q, tk_cnt_d;

  assign br_cnt_d = br_cnt_q + {31'd0, (w_accept && w_is_br)};
  assign tk_cnt_d = tk_cnt_q + {31'd0, taken_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_ctrl : directed vector table plus multi-cycle flush/reset sequences.
// Rev 1.0
// ============================================================================
module tb_branch_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic        sf;
    logic [3:0]  fl;
    logic        cz;
    logic        tk;
    logic        un;
    logic        fx;
    logic [18:0] c19;
    logic [25:0] a26;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        set_flags;
  logic [3:0]  alu_flags;
  logic        cbz_zero;

  logic        un1, tk1, fl1, un3, tk3, fl3;
  logic [18:0] c1, c3;
  logic [25:0] a1, a3;
`ifdef BRANCH_STATS_EN
  logic [31:0] bc1, tc1, bc3, tc3;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .set_flags(set_flags), .alu_flags(alu_flags), .cbz_zero(cbz_zero),
    .uncondBr(un1), .brTaken(tk1), .condAddr19(c1), .brAddr26(a1),
`ifdef BRANCH_STATS_EN
    .br_count(bc1), .taken_count(tc1),
`endif
    .flush(fl1)
  );

  branch_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .set_flags(set_flags), .alu_flags(alu_flags), .cbz_zero(cbz_zero),
    .uncondBr(un3), .brTaken(tk3), .condAddr19(c3), .brAddr26(a3),
`ifdef BRANCH_STATS_EN
    .br_count(bc3), .taken_count(tc3),
`endif
    .flush(fl3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic sf, input logic [3:0] f, input logic cz);
    instr_valid = 1'b1;
    instr       = i;
    set_flags   = sf;
    alu_flags   = f;
    cbz_zero    = cz;
  endtask

  task automatic idle_in();
    instr_valid = 1'b0;
    instr       = 32'h0;
    set_flags   = 1'b0;
    alu_flags   = 4'h0;
    cbz_zero    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic sf, input logic [3:0] f,
                              input logic cz, input logic tk, input logic un, input logic fx,
                              input logic [18:0] c19, input logic [25:0] a26);
    vec_t v;
    v.instr = i; v.sf = sf; v.fl = f; v.cz = cz;
    v.tk = tk; v.un = un; v.fx = fx; v.c19 = c19; v.a26 = a26;
    return v;
  endfunction

  initial begin
    // instr, set_flags, alu_flags, cbz_zero | brTaken, uncondBr, flush, condAddr19, brAddr26
    vecs.push_back(mk(32'h14000003, 0, 4'b0000, 0, 1, 1, 1, 19'd0, 26'h3));
    vecs.push_back(mk(32'h00000000, 1, 4'b0100, 0, 0, 0, 0, 19'd0, 26'h3));
    vecs.push_back(mk(32'h54000040, 0, 4'b0000, 0, 1, 0, 1, 19'd2, 26'h40));
    vecs.push_back(mk(32'h54000041, 0, 4'b0000, 0, 0, 0, 0, 19'd2, 26'h41));
    vecs.push_back(mk(32'hB4000060, 0, 4'b0000, 1, 1, 0, 1, 19'd3, 26'h60));
    vecs.push_back(mk(32'hB5000060, 0, 4'b0000, 1, 0, 0, 0, 19'd3, 26'h1000060));
    vecs.push_back(mk(32'h94000010, 0, 4'b0000, 0, 1, 1, 1, 19'd0, 26'h10));
    vecs.push_back(mk(32'h00000000, 1, 4'b1000, 0, 0, 0, 0, 19'd0, 26'h10));
    vecs.push_back(mk(32'h5400002A, 0, 4'b0000, 0, 0, 0, 0, 19'd1, 26'h2A));
    vecs.push_back(mk(32'h5400002B, 0, 4'b0000, 0, 1, 0, 1, 19'd1, 26'h2B));
    // B.EQ with same-cycle Z update: decision uses the old Z=0
    vecs.push_back(mk(32'h54000040, 1, 4'b0100, 0, 0, 0, 0, 19'd2, 26'h40));
    vecs.push_back(mk(32'h54000060, 0, 4'b0000, 0, 1, 0, 1, 19'd3, 26'h60));
    vecs.push_back(mk(32'h00000000, 1, 4'b0010, 0, 0, 0, 0, 19'd3, 26'h60));
    vecs.push_back(mk(32'h54000028, 0, 4'b0000, 0, 1, 0, 1, 19'd1, 26'h28));
    vecs.push_back(mk(32'h54000029, 0, 4'b0000, 0, 0, 0, 0, 19'd1, 26'h29));
    vecs.push_back(mk(32'hD65F03C0, 0, 4'b0000, 0, 0, 0, 0, 19'd1, 26'h29));
    vecs.push_back(mk(32'h5400000F, 0, 4'b0000, 0, 1, 0, 1, 19'd0, 26'hF));
    vecs.push_back(mk(32'hB4000020, 0, 4'b0000, 0, 0, 0, 0, 19'd1, 26'h20));

    do_reset();
    chk("rst_brTaken",  {31'd0, tk1}, 32'd0);
    chk("rst_uncondBr", {31'd0, un1}, 32'd0);
    chk("rst_flush",    {31'd0, fl1}, 32'd0);
    chk("rst_c19",      {13'd0, c1},  32'd0);
    chk("rst_a26",      {6'd0, a1},   32'd0);
    chk("rst_flush3",   {31'd0, fl3}, 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].instr, vecs[k].sf, vecs[k].fl, vecs[k].cz);
      cycle();
      chk($sformatf("v%0d_brTaken", k),  {31'd0, tk1}, {31'd0, vecs[k].tk});
      chk($sformatf("v%0d_uncondBr", k), {31'd0, un1}, {31'd0, vecs[k].un});
      chk($sformatf("v%0d_flush", k),    {31'd0, fl1}, {31'd0, vecs[k].fx});
      chk($sformatf("v%0d_c19", k),      {13'd0, c1},  {13'd0, vecs[k].c19});
      chk($sformatf("v%0d_a26", k),      {6'd0, a1},   {6'd0, vecs[k].a26});
      idle_in();
      cycle();
      chk($sformatf("v%0d_pulse_tk", k), {31'd0, tk1}, 32'd0);
      chk($sformatf("v%0d_pulse_un", k), {31'd0, un1}, 32'd0);
      chk($sformatf("v%0d_pulse_fl", k), {31'd0, fl1}, 32'd0);
    end

    // Back-to-back: the B.EQ in the flush cycle is squashed
    do_reset();
    drive(32'h00000000, 1, 4'b0100, 0);
    cycle();
    drive(32'h14000005, 0, 4'b0000, 0);
    cycle();
    chk("b2b_first_tk", {31'd0, tk1}, 32'd1);
    chk("b2b_first_fl", {31'd0, fl1}, 32'd1);
    drive(32'h54000040, 0, 4'b0000, 0);
    cycle();
    chk("b2b_second_tk", {31'd0, tk1}, 32'd0);
    chk("b2b_second_fl", {31'd0, fl1}, 32'd0);
    chk("b2b_c19_hold",  {13'd0, c1},  32'd0);
    chk("b2b_a26_hold",  {6'd0, a1},   32'd5);
    idle_in();

    // FLUSH_CYCLES=3: full window
    do_reset();
    drive(32'h14000001, 0, 4'b0000, 0);
    cycle();
    chk("f3_c1_tk", {31'd0, tk3}, 32'd1);
    chk("f3_c1_un", {31'd0, un3}, 32'd1);
    chk("f3_c1_fl", {31'd0, fl3}, 32'd1);
    drive(32'h14000002, 0, 4'b0000, 0);
    cycle();
    chk("f3_c2_tk", {31'd0, tk3}, 32'd0);
    chk("f3_c2_fl", {31'd0, fl3}, 32'd1);
    cycle();
    chk("f3_c3_tk", {31'd0, tk3}, 32'd0);
    chk("f3_c3_fl", {31'd0, fl3}, 32'd1);
    idle_in();
    cycle();
    chk("f3_c4_fl",  {31'd0, fl3}, 32'd0);
    chk("f3_a26",    {6'd0, a3},   32'd1);

    // FLUSH_CYCLES=3: reset in the 2nd flush cycle clears everything incl. NZCV
    do_reset();
    drive(32'h00000000, 1, 4'b0100, 0);
    cycle();
    drive(32'h14000001, 0, 4'b0000, 0);
    cycle();
    chk("f3r_tk", {31'd0, tk3}, 32'd1);
    idle_in();
    cycle();
    chk("f3r_fl2", {31'd0, fl3}, 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("f3r_fl_after", {31'd0, fl3}, 32'd0);
    chk("f3r_tk_after", {31'd0, tk3}, 32'd0);
    chk("f3r_a26_after", {6'd0, a3},  32'd0);
    drive(32'h54000040, 0, 4'b0000, 0);
    cycle();
    chk("f3r_beq_tk", {31'd0, tk3}, 32'd0);
    chk("f3r_beq_fl", {31'd0, fl3}, 32'd0);
    chk("f3r_beq_c19", {13'd0, c3}, 32'd2);
    idle_in();
    cycle();

`ifdef BRANCH_STATS_EN
    do_reset();
    chk("st_rst_br", bc1, 32'd0);
    chk("st_rst_tk", tc1, 32'd0);
    drive(32'h54000040, 0, 4'b0000, 0);  // B.EQ, Z=0: not taken
    cycle();
    drive(32'hB5000060, 0, 4'b0000, 1);  // CBNZ, zero: not taken
    cycle();
    chk("st_mid_br", bc1, 32'd2);
    chk("st_mid_tk", tc1, 32'd0);
    drive(32'h14000003, 0, 4'b0000, 0);  // B: taken
    cycle();
    idle_in();
    cycle();
    drive(32'hB4000060, 0, 4'b0000, 1);  // CBZ, zero: taken
    cycle();
    idle_in();
    cycle();
    chk("st_br", bc1, 32'd4);
    chk("st_tk", tc1, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
